// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver with oversampling tick counter, valid/ready byte output,
// framing and overrun pulses. Define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions.
module uart_rx #(
    parameter int CLOCK_FREQUENCY = 1_000_000,
    parameter int BAUD_RATE       = 9600,
    parameter int OVERSAMPLE      = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       RxWire,
    output logic [7:0] RxDataOutput,
    output logic       RxValid,
    input  logic       RxReady,
    output logic       RxBusy,
    output logic       RxFrameError,
    output logic       RxOverrun,
    output logic [2:0] dbg_state
);

    localparam int TICK_DIV = CLOCK_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int OS_W     = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [OS_W-1:0]  OS_EARLY   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  SAMPLE_IDX = OS_W'(OVERSAMPLE / 2 + 1);
`else
    localparam logic [OS_W-1:0]  SAMPLE_IDX = OS_MID;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [OS_W-1:0]  os_q, os_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
`ifdef UART_RX_MAJORITY_EN
    logic             samp_a_q, samp_a_d;
    logic             samp_b_q, samp_b_d;
`endif

    logic line;
    logic fall;
    logic tick;
    logic sample_evt;
    logic bit_val;
    logic deliver;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            div_q       <= '0;
            os_q        <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            samp_a_q    <= 1'b1;
            samp_b_q    <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            div_q       <= div_d;
            os_q        <= os_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_MAJORITY_EN
            samp_a_q    <= samp_a_d;
            samp_b_q    <= samp_b_d;
`endif
        end
    end

    // Output handshake: a byte transfers on the posedge where RxValid & RxReady are both 1;
    // RxValid then drops unless a new byte lands in that same cycle. RxReady is ignored while
    // RxValid is 0, and RxDataOutput is stable for as long as RxValid is held.
    always_comb begin
        line       = sync2_q;
        fall       = prev_q & ~sync2_q;
        tick       = (div_q == DIV_LAST);
        sample_evt = tick && (os_q == SAMPLE_IDX);

        sync1_d = RxWire;
        sync2_d = sync1_q;
        prev_d  = sync2_q;

        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
            os_d = (os_q == OS_LAST) ? '0 : os_q + 1'b1;
        end else begin
            os_d = os_q;
        end

`ifdef UART_RX_MAJORITY_EN
        samp_a_d = (tick && (os_q == OS_EARLY)) ? line : samp_a_q;
        samp_b_d = (tick && (os_q == OS_MID))   ? line : samp_b_q;
        bit_val  = (samp_a_q & samp_b_q) | (samp_a_q & line) | (samp_b_q & line);
`else
        bit_val  = line;
`endif

        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q & ~RxReady;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d = S_START;
                    div_d   = '0;
                    os_d    = '0;
                end
            end
            S_START: begin
                if (sample_evt) begin
                    if (!bit_val) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d   = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (sample_evt) begin
                    shift_d   = {bit_val, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                // Leaving at mid stop bit lets the next start edge be seen early.
                if (sample_evt) begin
                    if (bit_val) begin
                        state_d = S_IDLE;
                        deliver = 1'b1;
                    end else begin
                        state_d     = S_WAIT;
                        frame_err_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (line) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (deliver) begin
            if (valid_q && !RxReady) begin
                overrun_d = 1'b1;
            end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end
        end
    end

    assign RxDataOutput = data_q;
    assign RxValid      = valid_q;
    assign RxBusy       = (state_q != S_IDLE);
    assign RxFrameError = frame_err_q;
    assign RxOverrun    = overrun_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx at 16 Clk per bit; a negedge monitor records
// transfers and pulses, and each scenario task compares against hand-computed expectations.
module tb_uart_rx;

    localparam int BIT_CLKS = 16;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       RxWire;
    logic [7:0] RxDataOutput;
    logic       RxValid;
    logic       RxReady;
    logic       RxBusy;
    logic       RxFrameError;
    logic       RxOverrun;
    logic [2:0] dbg_state;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int valid_cyc = 0;
    int busy_cyc  = 0;
    int fe_cnt    = 0;
    int ov_cnt    = 0;

    uart_rx #(
        .CLOCK_FREQUENCY(160_000),
        .BAUD_RATE      (10_000),
        .OVERSAMPLE     (16)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .RxWire      (RxWire),
        .RxDataOutput(RxDataOutput),
        .RxValid     (RxValid),
        .RxReady     (RxReady),
        .RxBusy      (RxBusy),
        .RxFrameError(RxFrameError),
        .RxOverrun   (RxOverrun),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    always #5 Clk = ~Clk;

    // monitor: inputs change 2ns after posedge, sampled here at negedge
    always @(negedge Clk) begin
        if (Reset) begin
            if (RxValid && RxReady) got_q.push_back(RxDataOutput);
            if (RxValid)      valid_cyc++;
            if (RxBusy)       busy_cyc++;
            if (RxFrameError) fe_cnt++;
            if (RxOverrun)    ov_cnt++;
        end
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #2;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        RxWire = 1'b0;
        step(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            RxWire = b[i];
            step(BIT_CLKS);
        end
        RxWire = 1'b1;
        step(BIT_CLKS);
    endtask

    task automatic send_bad_stop(input logic [7:0] b);
        RxWire = 1'b0;
        step(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            RxWire = b[i];
            step(BIT_CLKS);
        end
        step(2 * BIT_CLKS);
        RxWire = 1'b1;
    endtask

    // scenarios
    task automatic test_reset;
        Reset   = 1'b0;
        RxWire  = 1'b1;
        RxReady = 1'b0;
        step(3);
        checks++; if (RxDataOutput !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", RxDataOutput); end
        checks++; if (RxValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", RxValid); end
        checks++; if (RxBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", RxBusy); end
        checks++; if (RxFrameError !== 1'b0 || RxOverrun !== 1'b0) begin errors++; $display("FAIL reset_flags: got fe=%b ov=%b want 0 0", RxFrameError, RxOverrun); end
        checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        Reset = 1'b1;
        step(5);
    endtask

    task automatic test_single;
        int v0, b0, f0, o0;
        RxReady = 1'b1;
        v0 = valid_cyc; b0 = busy_cyc; f0 = fe_cnt; o0 = ov_cnt;
        exp_q.push_back(8'hA5);
        send_byte(8'hA5);
        step(4);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL single_count: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (valid_cyc - v0 != 1) begin errors++; $display("FAIL single_valid_len: got %0d cycles want 1", valid_cyc - v0); end
        checks++; if (fe_cnt - f0 != 0 || ov_cnt - o0 != 0) begin errors++; $display("FAIL single_flags: got fe=%0d ov=%0d want 0 0", fe_cnt - f0, ov_cnt - o0); end
        checks++; if (busy_cyc - b0 < 150 || busy_cyc - b0 > 156) begin errors++; $display("FAIL single_busy_len: got %0d want 150..156", busy_cyc - b0); end
        checks++; if (RxBusy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", RxBusy); end
        exp_q.delete(); got_q.delete();
        step(20);
    endtask

    task automatic test_back_to_back;
        RxReady = 1'b1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_byte(8'h00);
        send_byte(8'hFF);
        step(4);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        exp_q.delete(); got_q.delete();
        step(20);
    endtask

    task automatic test_glitch;
        int v0, b0, f0, o0;
        v0 = valid_cyc; b0 = busy_cyc; f0 = fe_cnt; o0 = ov_cnt;
        RxWire = 1'b0;
        step(4);
        RxWire = 1'b1;
        step(30);
        checks++; if (busy_cyc - b0 < 8 || busy_cyc - b0 > 12) begin errors++; $display("FAIL glitch_busy_len: got %0d want 8..12", busy_cyc - b0); end
        checks++; if (RxBusy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got busy=%b want 0", RxBusy); end
        checks++; if (valid_cyc - v0 != 0) begin errors++; $display("FAIL glitch_valid: got %0d cycles want 0", valid_cyc - v0); end
        checks++; if (fe_cnt - f0 != 0 || ov_cnt - o0 != 0) begin errors++; $display("FAIL glitch_flags: got fe=%0d ov=%0d want 0 0", fe_cnt - f0, ov_cnt - o0); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL glitch_bytes: got %0d want 0", got_q.size()); end
        got_q.delete();
        step(10);
    endtask

    task automatic test_frame_error;
        int f0, o0;
        RxReady = 1'b1;
        f0 = fe_cnt; o0 = ov_cnt;
        send_bad_stop(8'h55);
        step(2 * BIT_CLKS);
        checks++; if (fe_cnt - f0 != 1) begin errors++; $display("FAIL ferr_pulses: got %0d want 1", fe_cnt - f0); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL ferr_no_delivery: got %0d bytes want 0", got_q.size()); end
        checks++; if (RxBusy !== 1'b0) begin errors++; $display("FAIL ferr_recover: got busy=%b want 0", RxBusy); end
        got_q.delete();
        exp_q.push_back(8'h3C);
        send_byte(8'h3C);
        step(4);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ferr_next_count: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ferr_next_byte: got %h want %h", got_q[i], exp_q[i]); end
        end
        checks++; if (fe_cnt - f0 != 1 || ov_cnt - o0 != 0) begin errors++; $display("FAIL ferr_flags_total: got fe=%0d ov=%0d want 1 0", fe_cnt - f0, ov_cnt - o0); end
        exp_q.delete(); got_q.delete();
        step(20);
    endtask

    task automatic test_overrun;
        int f0, o0;
        RxReady = 1'b0;
        f0 = fe_cnt; o0 = ov_cnt;
        send_byte(8'h11);
        send_byte(8'h22);
        step(4);
        checks++; if (RxValid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %b want 1", RxValid); end
        checks++; if (RxDataOutput !== 8'h11) begin errors++; $display("FAIL ovr_data_kept: got %h want 11", RxDataOutput); end
        checks++; if (ov_cnt - o0 != 1) begin errors++; $display("FAIL ovr_pulses: got %0d want 1", ov_cnt - o0); end
        checks++; if (fe_cnt - f0 != 0) begin errors++; $display("FAIL ovr_no_ferr: got %0d want 0", fe_cnt - f0); end
        exp_q.push_back(8'h11);
        RxReady = 1'b1;
        step(1);
        RxReady = 1'b0;
        step(1);
        checks++; if (RxValid !== 1'b0) begin errors++; $display("FAIL ovr_consume: got valid=%b want 0", RxValid); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovr_count: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovr_byte: got %h want %h", got_q[i], exp_q[i]); end
        end
        exp_q.delete(); got_q.delete();
        step(20);
    endtask

    task automatic test_mid_reset;
        logic [7:0] b;
        b = 8'h99;
        RxReady = 1'b0;
        send_byte(8'h5A);
        step(4);
        checks++; if (RxValid !== 1'b1 || RxDataOutput !== 8'h5A) begin errors++; $display("FAIL mrst_pending: got valid=%b data=%h want 1 5a", RxValid, RxDataOutput); end
        RxWire = 1'b0;
        step(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            RxWire = b[i];
            step(BIT_CLKS);
        end
        RxWire = b[4];
        step(BIT_CLKS / 2);
        checks++; if (RxBusy !== 1'b1) begin errors++; $display("FAIL mrst_busy_before: got %b want 1", RxBusy); end
        Reset = 1'b0;
        step(2);
        checks++; if (RxDataOutput !== 8'h00) begin errors++; $display("FAIL mrst_data: got %h want 00", RxDataOutput); end
        checks++; if (RxValid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b want 0", RxValid); end
        checks++; if (RxBusy !== 1'b0 || dbg_state !== 3'd0) begin errors++; $display("FAIL mrst_idle: got busy=%b state=%0d want 0 0", RxBusy, dbg_state); end
        checks++; if (RxFrameError !== 1'b0 || RxOverrun !== 1'b0) begin errors++; $display("FAIL mrst_flags: got fe=%b ov=%b want 0 0", RxFrameError, RxOverrun); end
        step(1);
        RxWire = 1'b1;
        Reset  = 1'b1;
        RxReady = 1'b1;
        step(3 * BIT_CLKS);
        got_q.delete();
        exp_q.push_back(8'h42);
        send_byte(8'h42);
        step(4);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL mrst_next_count: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mrst_next_byte: got %h want %h", got_q[i], exp_q[i]); end
        end
        exp_q.delete(); got_q.delete();
        step(20);
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_majority;
        logic [7:0] b;
        b = 8'hF0;
        RxReady = 1'b1;
        exp_q.push_back(8'hF0);
        RxWire = 1'b0;
        step(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            RxWire = b[i];
            step(BIT_CLKS / 2);
            RxWire = ~b[i];
            step(1);
            RxWire = b[i];
            step(BIT_CLKS / 2 - 1);
        end
        RxWire = 1'b1;
        step(BIT_CLKS);
        step(4);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL maj_count: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL maj_byte: got %h want %h", got_q[i], exp_q[i]); end
        end
        exp_q.delete(); got_q.delete();
        step(20);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_mid_reset();
`ifdef UART_RX_MAJORITY_EN
        test_majority();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
